instr_sequencer: RTL and testbench

Upstream stage of the processor. Holds a small writable program store of {instruction, immediate data} pairs and a program counter. It drives the processor's instruction_F, data and w inputs, one instruction per clock. Supports run, pause, single-step and halt-on-opcode so benches and the top level can execute programs without hand-driving every instruction.

---
 rtl/instr_sequencer_pkg.sv | 41 ++++
 rtl/instr_sequencer_if.sv | 30 +++
 rtl/instr_sequencer_prog_mem.sv | 29 ++
 rtl/instr_sequencer.sv | 123 ++++++++++++
 tb/tb_instr_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared widths, opcode constants, entry layout and FSM encoding for the
// instruction sequencer and its program store.
package seq_pkg;

  localparam int INSTR_W = 12;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_MOVE = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  data;
  } entry_t;

  // Instruction layout: opcode[11:8], rx[7:4], ry[3:0]
  function automatic logic [3:0] opcodeOf(input logic [INSTR_W-1:0] instr);
    return instr[11:8];
  endfunction

  function automatic logic [3:0] rxOf(input logic [INSTR_W-1:0] instr);
    return instr[7:4];
  endfunction

  function automatic logic [3:0] ryOf(input logic [INSTR_W-1:0] instr);
    return instr[3:0];
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Control/programming bus of the sequencer: the master loads and steers
// programs, the slave (sequencer) drives the processor-facing outputs.
interface instr_sequencer_if;
  import seq_pkg::*;

  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [INSTR_W-1:0] prog_instr;
  logic [DATA_W-1:0]  prog_data;
  logic               start;
  logic               halt_req;
  logic               step;
  logic [INSTR_W-1:0] instruction_F;
  logic [DATA_W-1:0]  data;
  logic               w;
  logic [ADDR_W-1:0]  pc;
  logic               busy;
  logic               done;

  modport master (
    output prog_we, prog_addr, prog_instr, prog_data, start, halt_req, step,
    input  instruction_F, data, w, pc, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_instr, prog_data, start, halt_req, step,
    output instruction_F, data, w, pc, busy, done
  );

endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: register array cleared by reset so every entry reads as
// HALT, with a synchronous write port and a combinational read port.
module prog_mem
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  entry_t            i_wentry,
  input  logic [ADDR_W-1:0] i_raddr,
  output entry_t            o_rentry
);

  entry_t r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wentry;
    end
  end

  assign o_rentry = r_mem[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Feeds the processor one stored instruction per clock, with run, pause,
// single-step and halt-on-opcode control.
module instr_sequencer
  import seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  instr_sequencer_if.slave bus
);

  state_t             r_state;
  state_t             w_nextState;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_nextPc;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] w_nextInstr;
  logic [DATA_W-1:0]  r_data;
  logic [DATA_W-1:0]  w_nextData;
  logic               r_w;
  logic               w_nextW;

  entry_t             w_entry;
  entry_t             w_progEntry;
  logic               w_memWe;
  logic               w_isHalt;
  logic               w_isLast;

  // The store is frozen while a program is actively running
  assign w_memWe     = bus.prog_we && (r_state != S_RUN);
  assign w_progEntry = '{instr: bus.prog_instr, data: bus.prog_data};

  prog_mem u_mem (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_memWe),
    .i_waddr  (bus.prog_addr),
    .i_wentry (w_progEntry),
    .i_raddr  (r_pc),
    .o_rentry (w_entry)
  );

  assign w_isHalt = (opcodeOf(w_entry.instr) == OP_HALT);
  assign w_isLast = (r_pc == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_instr <= '0;
      r_data  <= '0;
      r_w     <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
      r_instr <= w_nextInstr;
      r_data  <= w_nextData;
      r_w     <= w_nextW;
    end
  end

  // Issue in RUN and on a PAUSE step share one path; the last entry ends the
  // program without wrapping back to address 0.
  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_nextInstr = r_instr;
    w_nextData  = r_data;
    w_nextW     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_nextState = S_RUN;
          w_nextPc    = '0;
        end
      end
      S_RUN: begin
        if (bus.halt_req) begin
          w_nextState = S_PAUSE;
        end else if (w_isHalt) begin
          w_nextState = S_DONE;
        end else begin
          w_nextInstr = w_entry.instr;
          w_nextData  = w_entry.data;
          w_nextW     = 1'b1;
          if (w_isLast) begin
            w_nextState = S_DONE;
          end else begin
            w_nextPc = r_pc + ADDR_W'(1);
          end
        end
      end
      S_PAUSE: begin
        if (bus.start) begin
          w_nextState = S_RUN;
        end else if (bus.step) begin
          if (w_isHalt) begin
            w_nextState = S_DONE;
          end else begin
            w_nextInstr = w_entry.instr;
            w_nextData  = w_entry.data;
            w_nextW     = 1'b1;
            if (w_isLast) begin
              w_nextState = S_DONE;
            end else begin
              w_nextPc = r_pc + ADDR_W'(1);
            end
          end
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  assign bus.instruction_F = r_instr;
  assign bus.data          = r_data;
  assign bus.w             = r_w;
  assign bus.pc            = r_pc;
  assign bus.busy          = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign bus.done          = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a per-cycle vector table for the
// run/pause/step sequences plus a scoreboard of every issued instruction.
module tb_instr_sequencer;
  import seq_pkg::*;

  typedef struct {
    logic        start;
    logic        halt;
    logic        step;
    logic        expW;
    logic [11:0] expInstr;
    logic [15:0] expData;
    logic [3:0]  expPc;
    logic        expBusy;
    logic        expDone;
  } vec_t;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;
  int   issueCount;
  logic [27:0] expQ[$];
  vec_t vecs[17];

  instr_sequencer_if bus();

  instr_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every cycle carrying w=1 must match the oldest expected issue
  always @(negedge clk) begin
    if (rst && bus.w) begin
      issueCount++;
      testsRun++;
      if (expQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL unexpectedIssue: got instr %03h data %04h, none expected",
                 bus.instruction_F, bus.data);
      end else begin
        logic [27:0] exp;
        exp = expQ.pop_front();
        if ({bus.instruction_F, bus.data} !== exp) begin
          testsFailed++;
          $display("[TB] FAIL issue: got %03h/%04h expected %03h/%04h",
                   bus.instruction_F, bus.data, exp[27:16], exp[15:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic h, input logic st);
    bus.start    = s;
    bus.halt_req = h;
    bus.step     = st;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.halt_req = 1'b0;
    bus.step     = 1'b0;
  endtask

  task automatic loadEntry(input logic [3:0] addr, input logic [11:0] instr,
                           input logic [15:0] d);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = addr;
    bus.prog_instr = instr;
    bus.prog_data  = d;
    @(posedge clk);
    #1;
    bus.prog_we = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      if (bus.done) break;
      @(posedge clk);
      #1;
    end
    checkOutput("doneTimeout", 32'(bus.done), 32'd1);
  endtask

  task automatic pushExp(input logic [11:0] instr, input logic [15:0] d);
    expQ.push_back({instr, d});
  endtask

  task automatic loadProgram1();
    loadEntry(4'd0, 12'h100, 16'd1);
    loadEntry(4'd1, 12'h210, 16'd1);
    loadEntry(4'd2, 12'h301, 16'd1);
    loadEntry(4'd3, 12'h000, 16'd0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    issueCount  = 0;
    rst            = 1'b0;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_instr = '0;
    bus.prog_data  = '0;
    bus.start      = 1'b0;
    bus.halt_req   = 1'b0;
    bus.step       = 1'b0;

    // Rows: inputs before an edge, outputs expected just after it
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 16'd0, 4'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h100, 16'd1, 4'd1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h210, 16'd1, 4'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h301, 16'd1, 4'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h301, 16'd1, 4'd3, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h301, 16'd1, 4'd3, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h301, 16'd1, 4'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h100, 16'd1, 4'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h100, 16'd1, 4'd1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h100, 16'd1, 4'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h100, 16'd1, 4'd1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h210, 16'd1, 4'd2, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h210, 16'd1, 4'd2, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 12'h210, 16'd1, 4'd2, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h301, 16'd1, 4'd3, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h301, 16'd1, 4'd3, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h301, 16'd1, 4'd3, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetW", 32'(bus.w), 32'd0);
    checkOutput("resetPc", 32'(bus.pc), 32'd0);
    checkOutput("resetInstr", 32'(bus.instruction_F), 32'd0);
    checkOutput("resetBusyDone", 32'({bus.busy, bus.done}), 32'd0);
    rst = 1'b1;

    $display("[TB] program run, halt, step and resume");
    loadProgram1();
    pushExp(12'h100, 16'd1); pushExp(12'h210, 16'd1); pushExp(12'h301, 16'd1);
    pushExp(12'h100, 16'd1); pushExp(12'h210, 16'd1); pushExp(12'h301, 16'd1);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].start, vecs[i].halt, vecs[i].step);
      checkOutput($sformatf("v%0d_w", i), 32'(bus.w), 32'(vecs[i].expW));
      checkOutput($sformatf("v%0d_instr", i), 32'(bus.instruction_F), 32'(vecs[i].expInstr));
      checkOutput($sformatf("v%0d_data", i), 32'(bus.data), 32'(vecs[i].expData));
      checkOutput($sformatf("v%0d_pc", i), 32'(bus.pc), 32'(vecs[i].expPc));
      checkOutput($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("v%0d_done", i), 32'(bus.done), 32'(vecs[i].expDone));
    end

    $display("[TB] full store, no wrap-around");
    for (int a = 0; a < 16; a++) begin
      loadEntry(4'(a), 12'h301, 16'd2);
      pushExp(12'h301, 16'd2);
    end
    issueCount = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(40);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("fullIssues", 32'(issueCount), 32'd16);
    checkOutput("fullPc", 32'(bus.pc), 32'd15);
    checkOutput("fullDone", 32'(bus.done), 32'd1);

    $display("[TB] write during run ignored");
    loadProgram1();
    pushExp(12'h100, 16'd1); pushExp(12'h210, 16'd1); pushExp(12'h301, 16'd1);
    pushExp(12'h100, 16'd1); pushExp(12'h210, 16'd1); pushExp(12'h301, 16'd1);
    issueCount = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    loadEntry(4'd0, 12'h400, 16'd9);
    waitDone(20);
    checkOutput("runWritePc", 32'(bus.pc), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(20);
    checkOutput("restartIssues", 32'(issueCount), 32'd6);

    $display("[TB] asynchronous reset mid-run");
    pushExp(12'h100, 16'd1); pushExp(12'h210, 16'd1); pushExp(12'h301, 16'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("preResetW", 32'(bus.w), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncW", 32'(bus.w), 32'd0);
    checkOutput("asyncPc", 32'(bus.pc), 32'd0);
    checkOutput("asyncBusyDone", 32'({bus.busy, bus.done}), 32'd0);
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    issueCount = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("clearedBusy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("clearedDone", 32'(bus.done), 32'd1);
    checkOutput("clearedPc", 32'(bus.pc), 32'd0);
    checkOutput("clearedIssues", 32'(issueCount), 32'd0);

    $display("[TB] write in the same cycle as start");
    rst = 1'b0;
    #2;
    rst = 1'b1;
    issueCount = 0;
    pushExp(12'h1AB, 16'd7);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 4'd0;
    bus.prog_instr = 12'h1AB;
    bus.prog_data  = 16'd7;
    applyStimulus(1'b1, 1'b0, 1'b0);
    bus.prog_we = 1'b0;
    waitDone(10);
    checkOutput("sameCycleIssues", 32'(issueCount), 32'd1);
    checkOutput("sameCyclePc", 32'(bus.pc), 32'd1);

    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
